// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, N-bit operands, 2N-bit product, signed/unsigned per operation.
// Optional feature: define BOOTH_ZERO_BYPASS_EN to finish zero-operand operations without iterating.
`timescale 1ns/1ps

module booth_mult_seq #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             sgn,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   result
);

    localparam int W    = N + 1;
    localparam int ITER = W;
    localparam int CW   = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  m_reg;
    logic [W-1:0]  q_reg;
    logic [W:0]    acc;
    logic          q_m1;
    logic [CW-1:0] cnt;

    logic [W-1:0]  a_ext;
    logic [W-1:0]  b_ext;
    logic [W:0]    m_sext;
    logic [W:0]    acc_sum;
    logic [W:0]    acc_next;
    logic [W-1:0]  q_next;
    logic          q_m1_next;
    logic          last_step;

    // One extra bit lets unsigned operands with the top bit set stay positive in the signed datapath.
    assign a_ext  = {sgn & A[N-1], A};
    assign b_ext  = {sgn & B[N-1], B};
    assign m_sext = {m_reg[W-1], m_reg};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_sum = acc;
        case ({q_reg[0], q_m1})
            2'b01:   acc_sum = acc + m_sext;
            2'b10:   acc_sum = acc - m_sext;
            default: acc_sum = acc;
        endcase
    end

    assign acc_next  = {acc_sum[W], acc_sum[W:1]};
    assign q_next    = {acc_sum[0], q_reg[W-1:1]};
    assign q_m1_next = q_reg[0];
    assign last_step = (cnt == CW'(ITER - 1));

    assign ready = (state == S_IDLE);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            m_reg  <= '0;
            q_reg  <= '0;
            acc    <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
`ifdef BOOTH_ZERO_BYPASS_EN
                        if (A == '0 || B == '0) begin
                            cnt    <= '0;
                            result <= '0;
                            state  <= S_DONE;
                        end else
`endif
                        begin
                            m_reg <= a_ext;
                            q_reg <= b_ext;
                            acc   <= '0;
                            q_m1  <= 1'b0;
                            cnt   <= '0;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc  <= acc_next;
                    q_reg <= q_next;
                    q_m1 <= q_m1_next;
                    if (last_step) begin
                        // Low 2N bits of {acc[W-1:0], q} after this final step.
                        result <= {acc_next[N-2:0], q_next};
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier; next generation of the fixed 4-bit multiplier subsystem.
- Generalises operand width to N and product width to 2N.
- Adds a per-operation signed/unsigned mode, a ready/valid accept handshake and a busy flag.
- Sits between the operand-read subsystem and the result-display subsystem.
- Integrates FSM, iteration counter and datapath in one block.

Parameters:
N, 4, operand width in bits; legal range N >= 2; product width is 2N.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous reset, active-high.
valid  input  1  operands A, B, sgn present this cycle.
sgn  input  1  1 = two's-complement operands, 0 = unsigned operands.
A  input  N  multiplicand.
B  input  N  multiplier.
ready  output  1  block can accept an operation this cycle.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse: result valid.
result  output  2N  product; held until the next accepted operation.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - ready=1, busy=0, done=0, result=0.
  - All internal registers are cleared and the counter is zeroed.
- Internal width: W = N+1.
  - Operands are extended to W bits at accept: sign-extended when sgn=1, zero-extended when sgn=0.
  - Accumulator is W+1 bits so that subtracting the most-negative M cannot overflow.
  - Q register is W bits; Q-1 is 1 bit.
  - Iteration count is ITER = W in both modes, so latency is fixed.
- States:
  - IDLE: ready=1, busy=0.
    - On valid=1 at a rising edge (the accept edge): latch M=ext(A), Q=ext(B), Acc=0, Q-1=0, cnt=0 and the mode; go to CALC.
  - CALC: ready=0, busy=1. Each edge performs one Booth step:
    - {Q[0],Q-1}=01: Acc += sext(M).
    - {Q[0],Q-1}=10: Acc -= sext(M).
    - {Q[0],Q-1}=00 or 11: Acc unchanged.
    - In the same edge, arithmetic-shift {Acc,Q,Q-1} right by 1.
    - Then cnt += 1. When cnt reaches ITER-1 on this edge, go to DONE and register result = low 2N bits of {Acc[W-1:0],Q} after the step.
  - DONE: done=1, busy=1, ready=0. Next edge: go to IDLE, done=0.
- Latency:
  - done is high in the cycle following the ITER-th edge after the accept edge (N+1 edges; 5 for N=4).
  - ready returns high one edge later.
  - Throughput is one operation per ITER+2 cycles.
- Handshake:
  - valid while ready=0 is ignored; it is neither queued nor allowed to corrupt the operation.
  - A, B and sgn are sampled only on the accept edge and may change freely afterwards.
- result:
  - Changes only on the CALC->DONE edge.
  - Stable from done through the next CALC->DONE edge.
- Wrap-around: the counter never exceeds ITER-1; it is cleared on every accept.

Optional Feature:
Macro BOOTH_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if valid=1 and (A==0 or B==0), go directly to DONE with result=0, skipping CALC.
  - done is then high one cycle after the accept edge.
- Undefined:
  - Zero operands take the full ITER-step path.
  - The result is still 0.

Test Plan:
- N=4, sgn=1, A=4'h8, B=4'h8 (-8*-8): done exactly 5 edges after accept, result=8'h40; busy high 6 cycles.
- N=4, sgn=0, A=4'hF, B=4'hF (15*15): result=8'hE1. N=4, sgn=1, A=4'h7, B=4'h8 (7*-8): result=8'hC8.
- N=8, sgn=1, A=8'h80, B=8'h80: result=16'h4000. N=8, sgn=0, A=8'hFF, B=8'h02: result=16'h01FE.
- Start 3*5 (N=4, sgn=0); in cycle 2 assert valid with A=9, B=9 and change A/B: result=8'h0F, the second request is ignored, and ready stays low until DONE->IDLE.
- Assert rst two edges into CALC: immediately result=0, done=0, busy=0, ready=1; a following 2*3 (sgn=0) yields 8'h06.
- BOOTH_ZERO_BYPASS_EN defined, A=0, B=4'h5: done one cycle after accept, result=0. Macro undefined, same stimulus: done after 5 edges, result=0.
